seq_detect_sched: RTL and testbench

Time-multiplexed serial pattern detection engine shared by several bit-serial requesters. A round-robin arbiter grants one channel per cycle. The granted channel's saved history context is updated with its bit and compared against a programmable pattern of up to PW bits. Sits in front of the per-stream sequence-detection logic: one detector datapath plus a context store replaces NCH dedicated FSMs.

---
 rtl/seq_detect_sched.sv | 138 +++++++++++++
 tb/tb_seq_detect_sched.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_detect_sched.sv
// Time-multiplexed serial pattern detector: a round-robin arbiter picks one
// bit-serial channel per cycle and runs it through a shared detector using that channel's saved history.
module seq_detect_sched #(
  parameter int NCH = 4,
  parameter int PW  = 4,
  parameter int IDW = 2,
  parameter int LW  = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [NCH-1:0] in_valid,
  input  logic [NCH-1:0] in_bit,
  output logic [NCH-1:0] in_ready,
  input  logic           cfg_we,
  input  logic [PW-1:0]  cfg_pattern,
  input  logic [LW-1:0]  cfg_len,
  output logic           match,
  output logic [IDW-1:0] match_ch,
  output logic [7:0]     match_cnt
);

  localparam logic [LW-1:0] PW_L = LW'(PW);

  logic [IDW-1:0] ptr_r;
  logic [PW-1:0]  pat_r;
  logic [LW-1:0]  len_r;
  logic [PW-1:0]  hist_r [NCH];
  logic [LW-1:0]  fcnt_r [NCH];

  logic           found_s;
  logic           grant_s;
  logic [IDW-1:0] gid_s;
  logic [PW-1:0]  hsel_s;
  logic [LW-1:0]  fsel_s;
  logic [PW-1:0]  nhist_s;
  logic [LW-1:0]  nfcnt_s;
  logic [PW-1:0]  mask_s;
  logic           hit_s;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NCH;
    return IDW'(s);
  endfunction

  // Lengths outside 1..PW are pulled back into range
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    logic [LW-1:0] r;
    if (l == '0) begin
      r = LW'(1);
    end else if (l > PW_L) begin
      r = PW_L;
    end else begin
      r = l;
    end
    return r;
  endfunction

  // Round-robin scan starting at ptr_r: first valid channel wins
  always_comb begin
    found_s = 1'b0;
    gid_s   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!found_s && in_valid[rr_idx(ptr_r, k)]) begin
        found_s = 1'b1;
        gid_s   = rr_idx(ptr_r, k);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Shared detector datapath operating on the granted channel's context
  always_comb begin
    grant_s = found_s & en & ~cfg_we & ~reset;
    hsel_s  = hist_r[gid_s];
    fsel_s  = fcnt_r[gid_s];
    nhist_s = {hsel_s[PW-2:0], in_bit[gid_s]};
    if (fsel_s < PW_L) begin
      nfcnt_s = fsel_s + LW'(1);
    end else begin
      nfcnt_s = PW_L;
    end
    for (int b = 0; b < PW; b++) begin
      mask_s[b] = (LW'(b) < len_r);
    end
    hit_s = (nfcnt_s >= len_r) && (((nhist_s ^ pat_r) & mask_s) == '0);
    if (grant_s) begin
      in_ready = {{(NCH-1){1'b0}}, 1'b1} << gid_s;
    end else begin
      in_ready = '0;
    end
  end

  // Context store, configuration and match reporting
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r     <= '0;
      pat_r     <= '0;
      len_r     <= PW_L;
      match     <= 1'b0;
      match_ch  <= '0;
      match_cnt <= 8'd0;
      for (int i = 0; i < NCH; i++) begin
        hist_r[i] <= '0;
        fcnt_r[i] <= '0;
      end
    end else if (cfg_we) begin
      pat_r     <= cfg_pattern;
      len_r     <= clamp_len(cfg_len);
      match     <= 1'b0;
      match_cnt <= 8'd0;
      for (int i = 0; i < NCH; i++) begin
        hist_r[i] <= '0;
        fcnt_r[i] <= '0;
      end
    end else if (grant_s) begin
      ptr_r         <= rr_idx(gid_s, 1);
      hist_r[gid_s] <= nhist_s;
      fcnt_r[gid_s] <= nfcnt_s;
      match         <= hit_s;
      if (hit_s) begin
        match_ch <= gid_s;
        if (match_cnt != 8'd255) begin
          match_cnt <= match_cnt + 8'd1;
        end else begin
          match_cnt <= match_cnt;
        end
      end else begin
        match_ch <= match_ch;
      end
    end else begin
      match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched with hand-computed expectations.
module tb_seq_detect_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] in_valid;
  logic [3:0] in_bit;
  logic [3:0] in_ready;
  logic       cfg_we;
  logic [3:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic       match;
  logic [1:0] match_ch;
  logic [7:0] match_cnt;

  int checks = 0;
  int errors = 0;

  seq_detect_sched #(.NCH(4), .PW(4), .IDW(2), .LW(3)) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .match(match), .match_ch(match_ch), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit offered on a single channel; expects the grant and the next-cycle match
  task automatic send(input int ch, input logic b, input logic m, input string tag);
    logic [3:0] one;
    logic [3:0] bv;
    one      = 4'b0001;
    bv       = {3'b000, b};
    in_valid = one << ch;
    in_bit   = bv << ch;
    #1;
    check({tag, "_rdy"}, in_ready, one << ch);
    tick();
    check({tag, "_match"}, match, m);
  endtask

  task automatic cfg(input logic [3:0] p, input logic [2:0] l);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    in_valid    = 4'b0001;
    in_bit      = 4'b0001;
    #1;
    check("cfg_rdy", in_ready, 4'b0000);
    tick();
    check("cfg_match", match, 1'b0);
    check("cfg_cnt", match_cnt, 8'd0);
    cfg_we   = 1'b0;
    in_valid = 4'b0000;
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    reset = 1'b1; en = 1'b1; in_valid = 4'b1111; in_bit = 4'b0000;
    cfg_we = 1'b0; cfg_pattern = 4'b0000; cfg_len = 3'd0;
    #1;
    check("reset_rdy", in_ready, 4'b0000);
    tick();
    check("reset_match", match, 1'b0);
    check("reset_ch", match_ch, 2'd0);
    check("reset_cnt", match_cnt, 8'd0);

    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_rdy", in_ready, rr_exp[i]);
      tick();
    end
    in_valid = 4'b0100;
    #1;
    check("rr_only_ch2", in_ready, 4'b0100);
    tick();
    check("rr_match", match, 1'b0);

    en = 1'b0; in_valid = 4'b1111;
    #1;
    check("en_off_rdy", in_ready, 4'b0000);
    tick();
    en = 1'b1;

    cfg(4'b1011, 3'd4);
    send(0, 1'b1, 1'b0, "ov1");
    send(0, 1'b0, 1'b0, "ov2");
    send(0, 1'b1, 1'b0, "ov3");
    send(0, 1'b1, 1'b1, "ov4");
    check("ov4_ch", match_ch, 2'd0);
    check("ov4_cnt", match_cnt, 8'd1);
    send(0, 1'b0, 1'b0, "ov5");
    send(0, 1'b1, 1'b0, "ov6");
    send(0, 1'b1, 1'b1, "ov7");
    check("ov7_cnt", match_cnt, 8'd2);

    send(0, 1'b1, 1'b0, "mid1");
    send(0, 1'b0, 1'b0, "mid2");
    send(0, 1'b1, 1'b0, "mid3");
    cfg(4'b1011, 3'd4);
    send(0, 1'b1, 1'b0, "mid4");
    send(0, 1'b0, 1'b0, "mid5");
    send(0, 1'b1, 1'b0, "mid6");
    send(0, 1'b1, 1'b1, "mid7");
    check("mid_cnt", match_cnt, 8'd1);

    cfg(4'b0110, 3'd3);
    send(1, 1'b1, 1'b0, "iso1");
    send(3, 1'b1, 1'b0, "iso2");
    send(1, 1'b1, 1'b0, "iso3");
    send(3, 1'b1, 1'b0, "iso4");
    send(1, 1'b0, 1'b1, "iso5");
    check("iso5_ch", match_ch, 2'd1);
    send(3, 1'b0, 1'b1, "iso6");
    check("iso6_ch", match_ch, 2'd3);
    check("iso_cnt", match_cnt, 8'd2);
    in_valid = 4'b0000;
    tick();
    check("idle_match", match, 1'b0);
    check("idle_ch_hold", match_ch, 2'd3);

    cfg(4'b1111, 3'd7);
    send(2, 1'b1, 1'b0, "big1");
    send(2, 1'b1, 1'b0, "big2");
    send(2, 1'b1, 1'b0, "big3");
    send(2, 1'b1, 1'b1, "big4");
    check("big_ch", match_ch, 2'd2);

    cfg(4'b0001, 3'd0);
    in_valid = 4'b0001; in_bit = 4'b0001;
    for (int i = 0; i < 300; i++) begin
      tick();
      check("sat_match", match, 1'b1);
      if (i == 99) begin
        check("sat_cnt100", match_cnt, 8'd100);
      end
    end
    check("sat_cnt", match_cnt, 8'd255);

    reset = 1'b1; in_valid = 4'b1111;
    #1;
    check("rst2_rdy", in_ready, 4'b0000);
    tick();
    check("rst2_match", match, 1'b0);
    check("rst2_cnt", match_cnt, 8'd0);
    reset = 1'b0;
    #1;
    check("rst2_ptr", in_ready, 4'b0001);
    send(0, 1'b0, 1'b0, "post1");
    send(0, 1'b0, 1'b0, "post2");
    send(0, 1'b0, 1'b0, "post3");
    send(0, 1'b0, 1'b1, "post4");
    check("post_cnt", match_cnt, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
